// File: rtl/pulse_stretch_pkg.sv
// ----------------------------------------------------------------------------
// pulse_stretch_pkg
//
// Shared definitions for the pulse stretcher:
//   state_t         - FSM state encoding (IDLE, ON, GAP)
//   cycles_from_ms  - converts a clock frequency in Hz and a duration in ms
//                     into a clock-cycle count
//   MIN_PULSE_CYCLES- smallest usable on/gap length in cycles
// ----------------------------------------------------------------------------
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The FSM needs at least one "not last" counter value per phase.
    localparam int unsigned MIN_PULSE_CYCLES = 2;

    // Divide first so large clock frequencies do not overflow 32 bits.
    function automatic int unsigned cycles_from_ms(input int unsigned clk_freq,
                                                   input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// ----------------------------------------------------------------------------
// pulse_stretch
//
// Turns short event strobes into fixed-length pulses suitable for driving an
// LED or actuator. Each rising edge of strobe_in is one event. Every event
// produces a PULSE_CYCLES-long high pulse followed by a PULSE_CYCLES-long low
// gap. Events that arrive while a pulse or gap is in progress are queued (up
// to MAX_PENDING); further events are dropped and flagged in overflow.
//
// Ports:
//   clk       - single clock
//   rst       - asynchronous, active-high reset
//   strobe_in - event request, synchronous to clk
//   pulse_out - registered pulse drive, active high
//   busy      - high while a pulse/gap is running or events are queued
//   pending   - number of queued events not yet started
//   overflow  - sticky flag, set when an event is dropped
//   clr_ovf   - synchronous clear of overflow (a same-cycle set wins)
// ----------------------------------------------------------------------------
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned PULSE_MS    = 10,
    parameter int unsigned MAX_PENDING = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               strobe_in,
    input  logic                               clr_ovf,
    output logic                               pulse_out,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int unsigned PULSE_CYCLES = cycles_from_ms(CLK_FREQ, PULSE_MS);

    // Guarded so declarations stay legal while the elaboration error fires.
    localparam int CNT_W  = (PULSE_CYCLES < MIN_PULSE_CYCLES) ? 1 : $clog2(PULSE_CYCLES);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [PEND_W:0]   PEND_MAX_EXT = (PEND_W + 1)'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_MAX     = PEND_W'(MAX_PENDING);

    if (PULSE_CYCLES < MIN_PULSE_CYCLES) begin : g_bad_pulse_cycles
        $error("pulse_stretch: PULSE_CYCLES = CLK_FREQ/1000*PULSE_MS must be at least 2");
    end

    if (MAX_PENDING < 1) begin : g_bad_max_pending
        $error("pulse_stretch: MAX_PENDING must be at least 1");
    end

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [PEND_W-1:0] pending_nxt;
    logic              overflow_nxt;
    logic              strobe_prev;

    logic              strobe_event;
    logic              cnt_last;
    logic              may_launch;
    logic              launch;
    logic [PEND_W:0]   want;
    logic [PEND_W:0]   remain;
    logic              drop;

    // Rising-edge detect: a strobe held high is a single event.
    assign strobe_event = strobe_in & ~strobe_prev;
    assign cnt_last     = (cnt == CNT_LAST);

    // Queue bookkeeping treats the current event as if it had already been
    // queued. A pulse may start from IDLE or on the final GAP cycle; starting
    // one removes an entry. If the result still does not fit, the new event
    // is the one that gets dropped. This makes "event and start in the same
    // cycle" leave pending unchanged, including at saturation.
    always_comb begin
        want       = {1'b0, pending} + {{PEND_W{1'b0}}, strobe_event};
        may_launch = (state == IDLE) || ((state == GAP) && cnt_last);
        launch     = may_launch && (want != '0);
        remain     = want - {{PEND_W{1'b0}}, launch};
        drop       = 1'b0;
        pending_nxt = remain[PEND_W-1:0];
        if (remain > PEND_MAX_EXT) begin
            drop        = 1'b1;
            pending_nxt = PEND_MAX;
        end
    end

    // Next-state logic. The counter restarts on every state change, so it
    // never runs past CNT_LAST; in IDLE it simply stays at zero.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = ON;
                end
            end
            ON: begin
                if (cnt_last) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (cnt_last) begin
                    state_nxt = launch ? ON : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if ((state_nxt != state) || (state == IDLE)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // A drop in the same cycle as clr_ovf keeps the flag set.
    always_comb begin
        overflow_nxt = overflow;
        if (drop) begin
            overflow_nxt = 1'b1;
        end else if (clr_ovf) begin
            overflow_nxt = 1'b0;
        end
    end

    // pulse_out is registered from the next state so it is glitch-free and
    // rises on the same edge the FSM enters ON.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pending     <= '0;
            overflow    <= 1'b0;
            strobe_prev <= 1'b0;
            pulse_out   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pending     <= pending_nxt;
            overflow    <= overflow_nxt;
            strobe_prev <= strobe_in;
            pulse_out   <= (state_nxt == ON);
        end
    end

    assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_pulse_stretch.sv
// ----------------------------------------------------------------------------
// tb_pulse_stretch
//
// Self-checking bench for pulse_stretch with CLK_FREQ=100000, PULSE_MS=1
// (100-cycle pulses) and MAX_PENDING=3. A timestamp-based reference model
// predicts the outputs every cycle; directed scenarios add literal checks.
// ----------------------------------------------------------------------------
module tb_pulse_stretch;

    localparam int CLK_FREQ    = 100000;
    localparam int PULSE_MS    = 1;
    localparam int MAX_PENDING = 3;
    localparam int P           = 100;
    localparam int PW          = $clog2(MAX_PENDING + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          strobe_in;
    logic          clr_ovf;
    logic          pulse_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_stretch #(
        .CLK_FREQ   (CLK_FREQ),
        .PULSE_MS   (PULSE_MS),
        .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .strobe_in(strobe_in),
        .clr_ovf  (clr_ovf),
        .pulse_out(pulse_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the machine is occupied for 2*P edges after a pulse
    // starts; a queued or new event starts a pulse on the first edge where
    // the machine is free. Times are edge indices.
    longint m_cyc        = 0;
    longint m_last_start = -1000000;
    int     m_q          = 0;
    bit     m_ovf        = 1'b0;
    bit     m_prev       = 1'b0;
    int     m_total;
    bit     m_ev;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_last_start = -1000000;
                m_q          = 0;
                m_ovf        = 1'b0;
                m_prev       = 1'b0;
            end else begin
                m_cyc++;
                m_ev    = strobe_in && !m_prev;
                m_prev  = strobe_in;
                m_total = m_q + int'(m_ev);
                if ((m_cyc >= m_last_start + 2 * P) && (m_total > 0)) begin
                    m_last_start = m_cyc;
                    m_total--;
                end
                if (m_total > MAX_PENDING) begin
                    m_total = MAX_PENDING;
                    m_ovf   = 1'b1;
                end else if (clr_ovf) begin
                    m_ovf = 1'b0;
                end
                m_q = m_total;
            end
        end
    end

    // Per-cycle comparison against the model, plus a pulse counter used by
    // the directed scenarios.
    bit chk_en     = 1'b0;
    int pulse_cnt  = 0;
    bit pulse_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checkOutput("model_pulse", pulse_out, ((m_cyc - m_last_start) < P) ? 1 : 0);
                checkOutput("model_busy", busy,
                            (((m_cyc - m_last_start) < 2 * P) || (m_q != 0)) ? 1 : 0);
                checkOutput("model_pending", pending, m_q);
                checkOutput("model_overflow", overflow, m_ovf);
            end
            if (pulse_out === 1'b1 && !pulse_prev) pulse_cnt++;
            pulse_prev = (pulse_out === 1'b1);
        end
    end

    // Advance n active edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic s, input logic c, input int n);
        strobe_in = s;
        clr_ovf   = c;
        tick(n);
    endtask

    initial begin
        rst       = 1'b1;
        strobe_in = 1'b0;
        clr_ovf   = 1'b0;
        tick(2);
        checkOutput("reset_pulse", pulse_out, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pending", pending, 0);
        checkOutput("reset_overflow", overflow, 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick(3);

        // Single one-cycle strobe: 100 high, 100 gap, then idle.
        applyStimulus(1'b1, 1'b0, 1);
        strobe_in = 1'b0;
        checkOutput("single_first", pulse_out, 1);
        tick(99);
        checkOutput("single_last_high", pulse_out, 1);
        tick(1);
        checkOutput("single_gap_low", pulse_out, 0);
        checkOutput("single_gap_busy", busy, 1);
        tick(99);
        checkOutput("single_gap_end_busy", busy, 1);
        tick(1);
        checkOutput("single_idle_busy", busy, 0);
        tick(5);

        // Held-high strobe counts once.
        pulse_cnt = 0;
        applyStimulus(1'b1, 1'b0, 500);
        applyStimulus(1'b0, 1'b0, 50);
        checkOutput("held_pulse_count", pulse_cnt, 1);
        checkOutput("held_idle", busy, 0);

        // Three strobes 5 cycles apart: two queue behind the first.
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1);
            strobe_in = 1'b0;
            if (i < 2) tick(4);
        end
        checkOutput("three_pending_peak", pending, 2);
        checkOutput("three_pulse_high", pulse_out, 1);
        tick(600);
        checkOutput("three_pulse_count", pulse_cnt, 3);
        checkOutput("three_idle", busy, 0);

        // Six rapid strobes: saturate, drop, overflow; last drop collides
        // with clr_ovf and must still leave overflow set.
        pulse_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, (i == 5), 1);
            applyStimulus(1'b0, 1'b0, 1);
        end
        checkOutput("sat_pending", pending, 3);
        checkOutput("sat_overflow_set_wins", overflow, 1);
        tick(850);
        checkOutput("sat_pulse_count", pulse_cnt, 4);
        checkOutput("sat_overflow_sticky", overflow, 1);
        applyStimulus(1'b0, 1'b1, 1);
        clr_ovf = 1'b0;
        checkOutput("sat_overflow_cleared", overflow, 0);
        tick(5);

        // Reset 50 cycles into a pulse with two events queued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1);
            applyStimulus(1'b0, 1'b0, 1);
        end
        checkOutput("rst_mid_pending", pending, 2);
        tick(44);
        checkOutput("rst_mid_before", pulse_out, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_pulse_drop", pulse_out, 0);
        checkOutput("rst_mid_pending_clr", pending, 0);
        tick(1);
        rst       = 1'b0;
        pulse_cnt = 0;
        tick(400);
        checkOutput("rst_mid_no_pulses", pulse_cnt, 0);

        // Strobe held through reset release is one event on the first edge.
        strobe_in = 1'b1;
        rst       = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        checkOutput("rst_held_strobe", pulse_out, 1);
        strobe_in = 1'b0;
        tick(210);
        checkOutput("rst_held_idle", busy, 0);

        // Strobe on the final GAP cycle restarts ON with no extra gap.
        applyStimulus(1'b1, 1'b0, 1);
        strobe_in = 1'b0;
        tick(199);
        checkOutput("lastgap_low", pulse_out, 0);
        applyStimulus(1'b1, 1'b0, 1);
        strobe_in = 1'b0;
        checkOutput("lastgap_restart", pulse_out, 1);
        checkOutput("lastgap_pending", pending, 0);
        tick(210);

        // Randomised traffic, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            strobe_in = ($urandom_range(0, 99) < 15);
            clr_ovf   = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 1499) == 0);
            tick(1);
        end
        rst       = 1'b0;
        strobe_in = 1'b0;
        clr_ovf   = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
